// File: rtl/sp_ram_ctrl.sv
// Single-port RAM controller with per-byte write enables, an optional
// output register and an optional zero-fill pass after reset.
//
// An access request is accepted on any rising edge where req=1 and the
// controller is READY. Every accepted request is acknowledged one cycle later.
// A read returns data after 1+OUT_REG cycles. While CLEAR runs, requests are
// dropped and are not queued.
module sp_ram_ctrl #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic                    ack,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    init_done
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Storage array, written through a single port with byte lanes.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
    logic                  init_done_q, init_done_d;
    logic                  ack_q, ack_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  accept;
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         wr_be;

    // Port arbitration: the CLEAR pass owns the write port; otherwise the
    // accepted request does.
    always_comb begin
        accept  = (state_q == ST_READY) && req;
        rd_en   = accept && !we;
        wr_en   = (state_q == ST_CLEAR) || (accept && we);
        wr_addr = (state_q == ST_CLEAR) ? clear_ptr_q : addr;
        wr_data = (state_q == ST_CLEAR) ? '0 : din;
        wr_be   = (state_q == ST_CLEAR) ? '1 : byte_en;
    end

    // Next-state logic for the FSM, the clear pointer and the response flags.
    always_comb begin
        // NOTE: every signal gets a default here first, so that no path through the block infers a latch.
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        init_done_d = init_done_q;
        ack_d       = accept;
        rd_valid_d  = rd_en;
        rd_data_d   = rd_en ? mem[addr] : rd_data_q;

        case (state_q)
            ST_CLEAR: begin
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == '1) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end
            end
            ST_READY: begin
                init_done_d = 1'b1;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Control and read-data registers. The reset also drops any ack or read
    // pulse that is still in flight.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so that every flop samples the pre-edge values.
        if (!reset_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clear_ptr_q <= '0;
            init_done_q <= 1'b0;
            ack_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            init_done_q <= init_done_d;
            ack_q       <= ack_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Byte-lane write port for the array.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset, so it maps to block RAM and a reset leaves its contents untouched.
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  dout_valid_q, dout_valid_d;

        // The optional output stage loads only when a read completes, so
        // dout holds its value across writes.
        always_comb begin
            dout_valid_d = rd_valid_q;
            dout_d       = rd_valid_q ? rd_data_q : dout_q;
        end

        // Output register, cleared by reset.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_q       <= dout_d;
                dout_valid_q <= dout_valid_d;
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end else begin : g_no_out_reg
        assign dout       = rd_data_q;
        assign dout_valid = rd_valid_q;
    end

    assign ack       = ack_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed bench for sp_ram_ctrl. All instances share one set of inputs.
// dut0 and dut1 both clear on reset; dut0 has no output register and dut1
// has one. dut2 skips the clear pass and is checked only for init_done.
module tb_sp_ram_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [NB-1:0] byte_en;

    logic          ack0, dv0, init0;
    logic [DW-1:0] dout0;
    logic          ack1, dv1, init1;
    logic [DW-1:0] dout1;
    logic          ack2, dv2, init2;
    logic [DW-1:0] dout2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .din(din),
        .byte_en(byte_en), .ack(ack0), .dout(dout0), .dout_valid(dv0), .init_done(init0)
    );

    sp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .din(din),
        .byte_en(byte_en), .ack(ack1), .dout(dout1), .dout_valid(dv1), .init_done(init1)
    );

    sp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .CLEAR_ON_RESET(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .din(din),
        .byte_en(byte_en), .ack(ack2), .dout(dout2), .dout_valid(dv2), .init_done(init2)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [NB-1:0] be, input string tag);
        req = 1'b1; we = 1'b1; addr = a; din = d; byte_en = be;
        tick();
        req = 1'b0; we = 1'b0; byte_en = '0;
        check({tag, "_ack0"}, 32'(ack0), 32'd1);
        check({tag, "_ack1"}, 32'(ack1), 32'd1);
        check({tag, "_dv0"},  32'(dv0),  32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        req = 1'b1; we = 1'b0; addr = a; byte_en = '0;
        tick();
        req = 1'b0;
        check({tag, "_ack0"},  32'(ack0), 32'd1);
        check({tag, "_ack1"},  32'(ack1), 32'd1);
        check({tag, "_dv0"},   32'(dv0),  32'd1);
        check({tag, "_dout0"}, dout0,     exp);
        check({tag, "_dv1e"},  32'(dv1),  32'd0);
        tick();
        check({tag, "_ack0x"}, 32'(ack0), 32'd0);
        check({tag, "_dv0x"},  32'(dv0),  32'd0);
        check({tag, "_dout0h"}, dout0,    exp);
        check({tag, "_dv1"},   32'(dv1),  32'd1);
        check({tag, "_dout1"}, dout1,     exp);
    endtask

    // Counts edges from reset release until dut0 reports init_done; bounded.
    task automatic wait_init(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!init0 && cyc < 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int ack_seen;
        int dut2_first;
        logic [DW-1:0] exp_rd [3];

        // Reset values.
        reset_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; din = '0; byte_en = '0;
        repeat (3) tick();
        check("rst_ack0",  32'(ack0),  32'd0);
        check("rst_dv0",   32'(dv0),   32'd0);
        check("rst_dout0", dout0,      32'd0);
        check("rst_init0", 32'(init0), 32'd0);
        check("rst_dout1", dout1,      32'd0);
        check("rst_init1", 32'(init1), 32'd0);
        check("rst_init2", 32'(init2), 32'd0);

        // First clear pass. A write to addr 1, issued mid-clear, must be ignored.
        reset_n    = 1'b1;
        cyc        = 0;
        ack_seen   = 0;
        dut2_first = 0;
        while (cyc < 40 && !init0) begin
            if (cyc == 4) begin
                req = 1'b1; we = 1'b1; addr = 4'd1; din = 32'hA5A5_A5A5; byte_en = '1;
            end else begin
                req = 1'b0; we = 1'b0; byte_en = '0;
            end
            tick();
            cyc++;
            if (ack0 || ack1) ack_seen++;
            if (init2 && dut2_first == 0) dut2_first = cyc;
        end
        req = 1'b0; we = 1'b0; byte_en = '0;
        check("clr_init_cycles", 32'(cyc),        32'd16);
        check("clr_init1",       32'(init1),      32'd1);
        check("clr_no_ack",      32'(ack_seen),   32'd0);
        check("noclr_init2",     32'(dut2_first), 32'd1);
        check("clr_dv0",         32'(dv0),        32'd0);

        // The write dropped during clear left addr 1 at zero; the same write
        // issued now is acked exactly once.
        do_read(4'd1, 32'h0, "clr_req_dropped");
        do_write(4'd1, 32'hA5A5_A5A5, 4'hF, "req_after_init");
        tick();
        check("req_after_init_once0", 32'(ack0), 32'd0);
        check("req_after_init_once1", 32'(ack1), 32'd0);

        // Byte-lane merge.
        do_write(4'd5, 32'h1122_3344, 4'hF, "wr5_full");
        do_write(4'd5, 32'hAABB_CCDD, 4'h5, "wr5_lanes");
        do_read(4'd5, 32'h11BB_33DD, "rd5_merge");

        // Read-after-write, then a no-op write that is still acked.
        do_write(4'd9, 32'hDEAD_BEEF, 4'hF, "wr9");
        do_read(4'd9, 32'hDEAD_BEEF, "raw9");
        do_write(4'd9, 32'h1234_5678, 4'h0, "wr9_be0");
        check("wr9_be0_dout0", dout0, 32'hDEAD_BEEF);
        check("wr9_be0_dout1", dout1, 32'hDEAD_BEEF);
        tick();
        check("wr9_be0_once",   32'(ack0), 32'd0);
        check("wr9_be0_dout0h", dout0,     32'hDEAD_BEEF);
        do_read(4'd9, 32'hDEAD_BEEF, "rd9_unchanged");

        // Back-to-back reads of addrs 1, 2, 3.
        do_write(4'd2, 32'h2222_2222, 4'hF, "wr2");
        do_write(4'd3, 32'h3333_3333, 4'hF, "wr3");
        exp_rd[0] = 32'hA5A5_A5A5;
        exp_rd[1] = 32'h2222_2222;
        exp_rd[2] = 32'h3333_3333;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                req = 1'b1; we = 1'b0; addr = AW'(k + 1);
            end else begin
                req = 1'b0;
            end
            tick();
            if (k < 3) begin
                check($sformatf("b2b_dv0_%0d", k),   32'(dv0), 32'd1);
                check($sformatf("b2b_dout0_%0d", k), dout0,    exp_rd[k]);
            end else begin
                check($sformatf("b2b_dv0_%0d", k),   32'(dv0), 32'd0);
                check($sformatf("b2b_dout0_%0d", k), dout0,    exp_rd[2]);
            end
            if (k >= 1 && k <= 3) begin
                check($sformatf("b2b_dv1_%0d", k),   32'(dv1), 32'd1);
                check($sformatf("b2b_dout1_%0d", k), dout1,    exp_rd[k-1]);
            end else begin
                check($sformatf("b2b_dv1_%0d", k),   32'(dv1), 32'd0);
            end
        end

        // Preload every word with a non-zero value.
        for (int i = 0; i < 16; i++) begin
            do_write(AW'(i), 32'hC0DE_0000 | 32'(i + 1), 4'hF, $sformatf("pre%0d", i));
        end

        // Reset during a read. The pending dut1 pulse and both acks are dropped.
        req = 1'b1; we = 1'b0; addr = 4'd5;
        tick();
        req = 1'b0;
        reset_n = 1'b0;
        tick();
        check("rstrd_dv1",   32'(dv1),  32'd0);
        check("rstrd_dout1", dout1,     32'd0);
        check("rstrd_ack1",  32'(ack1), 32'd0);
        check("rstrd_dv0",   32'(dv0),  32'd0);
        check("rstrd_dout0", dout0,     32'd0);

        // Reset again when the clear pointer reaches 7. Clear restarts at 0.
        reset_n = 1'b1;
        repeat (7) tick();
        check("midclr_init_low", 32'(init0), 32'd0);
        reset_n = 1'b0;
        tick();
        check("midclr_rst_init0", 32'(init0), 32'd0);
        check("midclr_rst_ack0",  32'(ack0),  32'd0);
        reset_n = 1'b1;
        wait_init(cyc);
        check("midclr_init_cycles", 32'(cyc),   32'd16);
        check("midclr_init1",       32'(init1), 32'd1);

        // The whole array now reads back as zero.
        for (int i = 0; i < 16; i++) begin
            do_read(AW'(i), 32'h0, $sformatf("zero%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
